mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_pkg.sv | 37 +++
 rtl/mdu_sequencer_iter.sv | 59 +++++
 rtl/mdu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Build option: MDU_DIV0_FAST_EN (checked in mdu_sequencer) enables the divide-by-zero fast path.
package mdu_sequencer_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic f3_is_div(funct3_e f);
        return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic logic f3_signed_a(funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic f3_signed_b(funct3_e f);
        return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/mdu_sequencer_iter.sv
// mdu_iter: 64-bit product/remainder shift register with one shift-add or
// restoring shift-subtract step per enabled cycle, on unsigned magnitudes.
module mdu_iter
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [2*XLEN-1:0]   acc_o
);

    localparam int unsigned ACC_W = 2 * XLEN;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN:0]    sum_c;
    logic [XLEN:0]    sh_c;
    logic [XLEN-1:0]  diff_c;
    logic             ge_c;
    logic [ACC_W-1:0] mul_next_c;
    logic [ACC_W-1:0] div_next_c;

    // Multiply: upper half accumulates the multiplicand while the multiplier shifts out low.
    assign sum_c      = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, a_i} : (XLEN+1)'(0));
    assign mul_next_c = {sum_c, acc_q[XLEN-1:1]};

    // Divide: the partial remainder after the shift stays below twice the divisor,
    // so a 32-bit difference is exact whenever the subtraction is taken.
    assign sh_c       = acc_q[ACC_W-1:XLEN-1];
    assign ge_c       = (sh_c >= {1'b0, b_i});
    assign diff_c     = sh_c[XLEN-1:0] - b_i;
    assign div_next_c = ge_c ? {diff_c, acc_q[XLEN-2:0], 1'b1}
                             : {sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = is_div_i ? {XLEN'(0), a_i} : {XLEN'(0), b_i};
        end else if (step_i) begin
            acc_d = is_div_i ? div_next_c : mul_next_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter and sign fix-up.
// Build option: define MDU_DIV0_FAST_EN to finish divide-by-zero in one cycle.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN,
    parameter int unsigned ITER = MDU_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CNT_W = $clog2(ITER);
    localparam int unsigned ACC_W = 2 * XLEN;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    funct3_e          op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [XLEN-1:0]  mag_a_q, mag_a_d;
    logic [XLEN-1:0]  mag_b_q, mag_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    funct3_e          f3_in_c;
    logic             accept_c;
    logic             sa_c, sb_c;
    logic [XLEN-1:0]  mag_a_c, mag_b_c;
    logic             iter_load_c, iter_step_c, iter_div_c;
    logic [XLEN-1:0]  iter_a_c, iter_b_c;
    logic [ACC_W-1:0] acc_c;
    logic [ACC_W-1:0] prod_c;
    logic [XLEN-1:0]  quo_c, rem_sel_c, quo_fix_c, rem_fix_c, fix_res_c;
    logic             b_zero_c;

    assign f3_in_c  = funct3_e'(funct3_i);
    assign accept_c = (state_q == S_IDLE) && start_i && !flush_i;
    assign sa_c     = f3_signed_a(f3_in_c) && rs1_i[XLEN-1];
    assign sb_c     = f3_signed_b(f3_in_c) && rs2_i[XLEN-1];
    assign mag_a_c  = sa_c ? -rs1_i : rs1_i;
    assign mag_b_c  = sb_c ? -rs2_i : rs2_i;

`ifdef MDU_DIV0_FAST_EN
    logic div0_c;
    assign div0_c = f3_is_div(f3_in_c) && (rs2_i == '0);
`endif

    // The iterator loads fresh magnitudes on accept and steps on the latched ones.
    assign iter_load_c = accept_c;
    assign iter_step_c = (state_q == S_CALC);
    assign iter_div_c  = accept_c ? f3_is_div(f3_in_c) : f3_is_div(op_q);
    assign iter_a_c    = accept_c ? mag_a_c : mag_a_q;
    assign iter_b_c    = accept_c ? mag_b_c : mag_b_q;

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (iter_load_c),
        .step_i   (iter_step_c),
        .is_div_i (iter_div_c),
        .a_i      (iter_a_c),
        .b_i      (iter_b_c),
        .acc_o    (acc_c)
    );

    // Sign fix-up; a zero divisor forces all-ones quotient and remainder = rs1.
    assign prod_c    = (sign_a_q ^ sign_b_q) ? -acc_c : acc_c;
    assign quo_c     = acc_c[XLEN-1:0];
    assign b_zero_c  = (mag_b_q == '0);
    assign quo_fix_c = b_zero_c ? '1 : ((sign_a_q ^ sign_b_q) ? -quo_c : quo_c);
    assign rem_sel_c = b_zero_c ? mag_a_q : acc_c[ACC_W-1:XLEN];
    assign rem_fix_c = sign_a_q ? -rem_sel_c : rem_sel_c;

    always_comb begin
        fix_res_c = '0;
        case (op_q)
            F3_MUL:                       fix_res_c = prod_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res_c = prod_c[ACC_W-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res_c = quo_fix_c;
            F3_REM, F3_REMU:              fix_res_c = rem_fix_c;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_CALC;
`ifdef MDU_DIV0_FAST_EN
                    if (div0_c) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // Output and datapath register updates
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        result_d = result_q;
        busy_d   = (state_d == S_CALC) || (state_d == S_FIX);
        done_d   = (state_d == S_DONE);

        if (accept_c) begin
            cnt_d    = CNT_W'(ITER - 1);
            op_d     = f3_in_c;
            sign_a_d = sa_c;
            sign_b_d = sb_c;
            mag_a_d  = mag_a_c;
            mag_b_d  = mag_b_c;
`ifdef MDU_DIV0_FAST_EN
            if (div0_c) begin
                result_d = f3_in_c[1] ? rs1_i : '1;
            end
`endif
        end

        if (state_q == S_CALC && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_q == S_FIX && state_d == S_DONE) begin
            result_d = fix_res_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            op_q     <= F3_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer; honours MDU_DIV0_FAST_EN for div-by-zero timing.
module tb_mdu_sequencer;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int LAT = 34;
`ifdef MDU_DIV0_FAST_EN
    localparam int LAT_DIV0 = 1;
`else
    localparam int LAT_DIV0 = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    mdu_sequencer dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start accepted in the current cycle (cycle 0); returns in the idle cycle after done_o.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        int nbusy;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        n      = 1;
        nbusy  = 0;
        while (!done_o && n < 200) begin
            if (busy_o) nbusy++;
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, " busy_at_done"}, 64'(busy_o), 64'(0));
        check({tag, " result"}, 64'(result_o), 64'(exp_res));
        tick();
        check({tag, " done_one_cycle"}, 64'(done_o), 64'(0));
    endtask

    initial begin
        int seen;
        int dcyc [3];
        int nd;

        repeat (3) tick();
        check("reset busy", 64'(busy_o), 64'(0));
        check("reset done", 64'(done_o), 64'(0));
        check("reset result", 64'(result_o), 64'(0));
        rst = 1'b1;
        tick();

        run_op("MUL 7*-3",      MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT);
        run_op("MULHU -1*-1",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
        run_op("MULH -1*-1",    MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT);
        run_op("MULHSU -1*max", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);
        run_op("MULHU 2^31*2",  MULHU,  32'h80000000, 32'd2,        32'h00000001, LAT);
        run_op("DIV -7/2",      DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT);
        run_op("REM -7/2",      REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT);
        run_op("DIV 7/-2",      DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT);
        run_op("REM 7/-2",      REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, LAT);
        run_op("DIV ovf",       DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT);
        run_op("REM ovf",       REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT);
        run_op("DIVU 100/7",    DIVU,   32'd100,      32'd7,        32'd14,       LAT);
        run_op("REMU 100/7",    REMU,   32'd100,      32'd7,        32'd2,        LAT);
        run_op("DIVU 5/0",      DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_DIV0);
        run_op("REM -5/0",      REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_DIV0);
        run_op("DIV 3/0",       DIV,    32'd3,        32'd0,        32'hFFFFFFFF, LAT_DIV0);
        run_op("REMU big/0",    REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, LAT_DIV0);

        // Flush a DIV at cycle 10, then MUL from cycle 11 finishes at cycle 45.
        funct3 = DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (int c = 1; c < 10; c++) begin
            if (done_o) seen++;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush no done", 64'(seen + int'(done_o)), 64'(0));
        check("flush busy c11", 64'(busy_o), 64'(0));
        check("flush keeps result", 64'(result_o), 64'(32'hFFFFFFF0));
        run_op("MUL after flush", MUL, 32'd6, 32'd7, 32'd42, LAT);

        // Flush and start together in IDLE: start dropped.
        funct3 = MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", 64'(busy_o), 64'(0));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o || busy_o) seen++;
            tick();
        end
        check("flush+start dropped", 64'(seen), 64'(0));
        check("flush+start result", 64'(result_o), 64'(42));

        // start held high: completions at 34, 69 and 104.
        funct3 = MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        nd = 0;
        dcyc = '{-1, -1, -1};
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (done_o) begin
                if (nd < 3) dcyc[nd] = c;
                nd++;
                check("stream result", 64'(result_o), 64'(15));
            end
        end
        start = 1'b0;
        check("stream done count", 64'(nd), 64'(3));
        check("stream done #1", 64'(dcyc[0]), 64'(34));
        check("stream done #2", 64'(dcyc[1]), 64'(69));
        check("stream done #3", 64'(dcyc[2]), 64'(104));

        // Reset during an in-flight operation abandons it.
        check("pre-reset busy", 64'(busy_o), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midop reset busy", 64'(busy_o), 64'(0));
        check("midop reset done", 64'(done_o), 64'(0));
        check("midop reset result", 64'(result_o), 64'(0));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o || busy_o) seen++;
            tick();
        end
        check("midop reset quiet", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
